spi_cmd_queue: RTL

//  Memory-mapped command queue and sequencer in front of the SPI 8-bit output driver (OLED, 62.5MHz domain).
//  CPU stores command/data/power/delay entries at LCD address 0xff0c without polling.

---
 rtl/spi_cmd_queue_if.sv | 19 +
 rtl/spi_cmd_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spi_cmd_queue_if.sv
// CPU-side write port and SPI-driver-side outputs of the OLED command queue.
interface spi_cmd_queue_if;
  logic        wr_en;
  logic [10:0] wr_data;
  logic [31:0] status;
  logic        busy;
  logic        spi_start;
  logic [9:0]  spi_din;

  modport master (
    output wr_en, wr_data,
    input  status, busy, spi_start, spi_din
  );

  modport slave (
    input  wr_en, wr_data,
    output status, busy, spi_start, spi_din
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// Command FIFO plus sequencer that pops byte/power/delay entries and paces
// start pulses to the SPI byte driver with fixed per-entry time slots.
module spi_cmd_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned XFER_CYCLES = 480,
  parameter int unsigned PWR_CYCLES  = 4,
  parameter int unsigned DELAY_UNIT  = 62500
) (
  input  logic            clk,
  input  logic            reset,
  spi_cmd_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DELAY
  } state_t;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          entry_pwr_q, entry_pwr_d;
  logic          spi_start_q, spi_start_d;
  logic [9:0]    spi_din_q, spi_din_d;

  logic          full, empty, push, pop;
  logic [10:0]   head;
  logic [23:0]   delay_len;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    push      = bus.wr_en && !full;
    pop       = (state_q == IDLE) && !empty;
    head      = mem_q[rd_ptr_q];
    delay_len = 24'(head[7:0]) * 24'(DELAY_UNIT);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    entry_pwr_d = entry_pwr_q;
    spi_start_d = 1'b0;
    spi_din_d   = spi_din_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (bus.wr_en && full) overflow_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          entry_pwr_d = head[9];
          // Delay bit outranks power-on; zero-tick delays are consumed in place.
          if (head[10]) begin
            if (head[7:0] != 8'd0) begin
              state_d = DELAY;
              cnt_d   = delay_len - 24'd1;
            end
          end else begin
            state_d     = ISSUE;
            spi_start_d = 1'b1;
            spi_din_d   = head[9:0];
          end
        end
      end
      ISSUE: begin
        state_d = XFER;
        cnt_d   = entry_pwr_q ? 24'(PWR_CYCLES - 1) : 24'(XFER_CYCLES - 1);
      end
      XFER, DELAY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 24'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      entry_pwr_q <= 1'b0;
      spi_start_q <= 1'b0;
      spi_din_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      entry_pwr_q <= entry_pwr_d;
      spi_start_q <= spi_start_d;
      spi_din_q   <= spi_din_d;
    end
  end

  assign bus.busy      = !empty || (state_q != IDLE);
  assign bus.status    = {23'd0, overflow_q, bus.busy, empty, full, 5'(count_q)};
  assign bus.spi_start = spi_start_q;
  assign bus.spi_din   = spi_din_q;

endmodule
